// File: rtl/taxi_axis_fifo_pause_ctrl.sv
// Watermark-driven pause controller for the sink side of the AXI4-Stream async FIFO,
// with saturating event/pause statistics. Lives in the FIFO s_clk domain.
module taxi_axis_fifo_pause_ctrl #(
   parameter int DEPTH     = 4096,
   parameter int HIGH_WM   = 3072,
   parameter int LOW_WM    = 1024,
   parameter int MIN_PAUSE = 16,
   parameter int CNT_W     = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     force_pause,
   input  logic                     clear_counters,
   input  logic [$clog2(DEPTH):0]   status_depth,
   input  logic                     status_overflow,
   input  logic                     status_bad_frame,
   input  logic                     status_good_frame,
   output logic                     pause_req,
   input  logic                     pause_ack,
   output logic                     paused,
   output logic [CNT_W-1:0]         cnt_overflow,
   output logic [CNT_W-1:0]         cnt_bad_frame,
   output logic [CNT_W-1:0]         cnt_good_frame,
   output logic [CNT_W-1:0]         cnt_pause_events,
   output logic [CNT_W-1:0]         cnt_pause_cycles
);

   localparam int DW   = $clog2(DEPTH) + 1;
   localparam int HW   = 16;
   localparam int NCNT = 5;

   localparam logic [DW-1:0] HIGH_C    = DW'(HIGH_WM);
   localparam logic [DW-1:0] LOW_C     = DW'(LOW_WM);
   localparam logic [HW-1:0] HOLD_INIT = HW'(MIN_PAUSE - 1);

   localparam int C_OVF    = 0;
   localparam int C_BAD    = 1;
   localparam int C_GOOD   = 2;
   localparam int C_PEVT   = 3;
   localparam int C_PCYC   = 4;

   if (!(LOW_WM < HIGH_WM && HIGH_WM <= DEPTH && MIN_PAUSE >= 1 && MIN_PAUSE <= 65535))
   begin : g_param_check
      $fatal(1, "taxi_axis_fifo_pause_ctrl: need LOW_WM < HIGH_WM <= DEPTH and 1 <= MIN_PAUSE <= 65535");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_PAUSED,
      ST_RELEASE
   } state_t;

   state_t                       state_q, state_d;
   logic [HW-1:0]                hold_q, hold_d;
   logic                         pause_req_q, pause_req_d;
   logic                         paused_q, paused_d;
   logic [NCNT-1:0][CNT_W-1:0]   cnt_q, cnt_d;
   logic [NCNT-1:0]              evt;
   logic                         want;
   logic                         low;
   logic                         pause_evt;

   // Force overrides both thresholds: it requests a pause and blocks release.
   assign want = force_pause | (enable & (status_depth >= HIGH_C));
   assign low  = ~force_pause & (~enable | (status_depth <= LOW_C));

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      pause_evt = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (want) begin
               state_d   = ST_REQ;
               pause_evt = 1'b1;
            end
         end
         ST_REQ: begin
            if (pause_ack) begin
               state_d = ST_PAUSED;
               hold_d  = HOLD_INIT;
            end else if (low) begin
               state_d = ST_IDLE;
            end
         end
         ST_PAUSED: begin
            if (hold_q == '0) begin
               if (low) begin
                  state_d = ST_RELEASE;
               end
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         ST_RELEASE: begin
            if (!pause_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs registered from the next state so they align with the state register.
      pause_req_d = (state_d == ST_REQ) || (state_d == ST_PAUSED);
      paused_d    = (state_d == ST_PAUSED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         pause_req_q <= 1'b0;
         paused_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         pause_req_q <= pause_req_d;
         paused_q    <= paused_d;
      end
   end

   always_comb begin
      evt         = '0;
      evt[C_OVF]  = status_overflow;
      evt[C_BAD]  = status_bad_frame;
      evt[C_GOOD] = status_good_frame;
      evt[C_PEVT] = pause_evt;
      evt[C_PCYC] = (state_q == ST_PAUSED);
   end

   always_comb begin
      cnt_d = cnt_q;
      for (int unsigned i = 0; i < NCNT; i++) begin
         if (clear_counters) begin
            cnt_d[i] = '0;
         end else if (evt[i] && (cnt_q[i] != '1)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign pause_req        = pause_req_q;
   assign paused           = paused_q;
   assign cnt_overflow     = cnt_q[C_OVF];
   assign cnt_bad_frame    = cnt_q[C_BAD];
   assign cnt_good_frame   = cnt_q[C_GOOD];
   assign cnt_pause_events = cnt_q[C_PEVT];
   assign cnt_pause_cycles = cnt_q[C_PCYC];

endmodule

// File: tb/tb_taxi_axis_fifo_pause_ctrl.sv
// Bench for taxi_axis_fifo_pause_ctrl: handshake vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_taxi_axis_fifo_pause_ctrl;

   localparam int DEPTH     = 16;
   localparam int HIGH_WM   = 12;
   localparam int LOW_WM    = 4;
   localparam int MIN_PAUSE = 8;
   localparam int CNT_W     = 4;
   localparam int CMAX      = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             enable = 1'b1;
   logic             force_pause = 1'b0;
   logic             clear_counters = 1'b0;
   logic [4:0]       status_depth = '0;
   logic             status_overflow = 1'b0;
   logic             status_bad_frame = 1'b0;
   logic             status_good_frame = 1'b0;
   logic             pause_ack = 1'b0;
   logic             pause_req;
   logic             paused;
   logic [CNT_W-1:0] cnt_overflow;
   logic [CNT_W-1:0] cnt_bad_frame;
   logic [CNT_W-1:0] cnt_good_frame;
   logic [CNT_W-1:0] cnt_pause_events;
   logic [CNT_W-1:0] cnt_pause_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: request/paused/release flags, cycles spent in the current pause, counters
   // indexed 0 ovf, 1 bad, 2 good, 3 pause events, 4 pause cycles.
   bit m_req, m_paused, m_rel;
   int m_pcount;
   int m_cnt[5];

   taxi_axis_fifo_pause_ctrl #(
      .DEPTH(DEPTH), .HIGH_WM(HIGH_WM), .LOW_WM(LOW_WM),
      .MIN_PAUSE(MIN_PAUSE), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .force_pause(force_pause),
      .clear_counters(clear_counters), .status_depth(status_depth),
      .status_overflow(status_overflow), .status_bad_frame(status_bad_frame),
      .status_good_frame(status_good_frame), .pause_req(pause_req),
      .pause_ack(pause_ack), .paused(paused), .cnt_overflow(cnt_overflow),
      .cnt_bad_frame(cnt_bad_frame), .cnt_good_frame(cnt_good_frame),
      .cnt_pause_events(cnt_pause_events), .cnt_pause_cycles(cnt_pause_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int c, input bit e);
      return (c + int'(e) > CMAX) ? CMAX : c + int'(e);
   endfunction

   task automatic model_reset();
      m_req = 0; m_paused = 0; m_rel = 0; m_pcount = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
   endtask

   task automatic model_update();
      int  d;
      bit  want, low, idle;
      d    = int'(status_depth);
      want = force_pause || (enable && d >= HIGH_WM);
      low  = !force_pause && (!enable || d <= LOW_WM);
      idle = !m_req && !m_rel;
      if (clear_counters) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
      end else begin
         m_cnt[0] = sat(m_cnt[0], status_overflow);
         m_cnt[1] = sat(m_cnt[1], status_bad_frame);
         m_cnt[2] = sat(m_cnt[2], status_good_frame);
         m_cnt[3] = sat(m_cnt[3], idle && want);
         m_cnt[4] = sat(m_cnt[4], m_paused);
      end
      if (m_paused) begin
         m_pcount++;
         if (m_pcount >= MIN_PAUSE && low) begin
            m_paused = 0; m_req = 0; m_rel = 1;
         end
      end else if (m_req) begin
         if (pause_ack) begin
            m_paused = 1; m_pcount = 0;
         end else if (low) begin
            m_req = 0;
         end
      end else if (m_rel) begin
         if (!pause_ack) m_rel = 0;
      end else if (want) begin
         m_req = 1;
      end
   endtask

   task automatic check_model();
      chk("pause_req", int'(pause_req), int'(m_req));
      chk("paused", int'(paused), int'(m_paused));
      chk("cnt_overflow", int'(cnt_overflow), m_cnt[0]);
      chk("cnt_bad_frame", int'(cnt_bad_frame), m_cnt[1]);
      chk("cnt_good_frame", int'(cnt_good_frame), m_cnt[2]);
      chk("cnt_pause_events", int'(cnt_pause_events), m_cnt[3]);
      chk("cnt_pause_cycles", int'(cnt_pause_cycles), m_cnt[4]);
   endtask

   // Inputs are driven 1 time unit after a rising edge; outputs checked 1 unit after the next.
   task automatic step(input bit fp, input bit en, input int d, input bit ack,
                       input bit ovf, input bit bad, input bit good, input bit clr);
      force_pause = fp; enable = en; status_depth = 5'(d); pause_ack = ack;
      status_overflow = ovf; status_bad_frame = bad; status_good_frame = good;
      clear_counters = clr;
      @(posedge clk);
      model_update();
      #1;
      check_model();
   endtask

   typedef struct {
      bit ack;
      int depth;
      bit req;
      bit pau;
   } vec_t;

   vec_t tbl[21];

   initial begin
      int n;
      // handshake walk: ramp, ack, hold, release, re-request in RELEASE, abort, ack+low tie
      tbl[0]  = '{0, 0, 0, 0};
      tbl[1]  = '{0, 8, 0, 0};
      tbl[2]  = '{0, 12, 1, 0};
      tbl[3]  = '{0, 12, 1, 0};
      tbl[4]  = '{1, 12, 1, 1};
      for (int i = 5; i <= 11; i++) tbl[i] = '{1, 3, 1, 1};
      tbl[12] = '{1, 3, 0, 0};
      tbl[13] = '{1, 3, 0, 0};
      tbl[14] = '{1, 12, 0, 0};
      tbl[15] = '{0, 12, 0, 0};
      tbl[16] = '{0, 12, 1, 0};
      tbl[17] = '{0, 2, 0, 0};
      tbl[18] = '{0, 2, 0, 0};
      tbl[19] = '{0, 12, 1, 0};
      tbl[20] = '{1, 2, 1, 1};

      model_reset();
      #11;
      check_model();
      #1 rst = 1'b0;

      for (int i = 0; i < 21; i++) begin
         step(0, 1, tbl[i].depth, tbl[i].ack, 0, 0, 0, 0);
         chk($sformatf("tbl%0d_pause_req", i), int'(pause_req), int'(tbl[i].req));
         chk($sformatf("tbl%0d_paused", i), int'(paused), int'(tbl[i].pau));
         if (i == 12) chk("tbl_pause_cycles_at_release", int'(cnt_pause_cycles), 8);
      end
      chk("tbl_pause_events", int'(cnt_pause_events), 3);

      for (int i = 0; i < 10; i++) step(0, 1, 2, 1, 0, 0, 0, 0);
      chk("late_release_req", int'(pause_req), 0);
      for (int i = 0; i < 2; i++) step(0, 1, 2, 0, 0, 0, 0, 0);

      // depth inside the hysteresis band must never request
      step(0, 1, 2, 0, 0, 0, 0, 1);
      for (int i = 0; i < 100; i++) step(0, 1, (i % 2) ? 11 : 5, 0, 0, 0, 0, 0);
      chk("band_pause_events", int'(cnt_pause_events), 0);
      chk("band_pause_req", int'(pause_req), 0);

      // depth falls right after entering PAUSED: hold still enforces 8 cycles
      step(0, 1, 12, 0, 0, 0, 0, 0);
      step(0, 1, 12, 1, 0, 0, 0, 0);
      n = 0;
      while (pause_req && n < 20) begin
         step(0, 1, 0, 1, 0, 0, 0, 0);
         n++;
      end
      chk("min_pause_cycles_seen", n, 8);
      chk("min_pause_cnt_cycles", int'(cnt_pause_cycles), 8);
      step(0, 1, 0, 0, 0, 0, 0, 0);

      // saturation and clear-wins-over-event
      step(0, 1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0, 1, 0);
      chk("good_saturated", int'(cnt_good_frame), 15);
      step(0, 1, 0, 0, 0, 1, 0, 0);
      chk("bad_one", int'(cnt_bad_frame), 1);
      step(0, 1, 0, 0, 0, 1, 0, 1);
      chk("bad_cleared", int'(cnt_bad_frame), 0);

      // force_pause with enable low still pauses; asynchronous reset while paused
      step(1, 0, 0, 0, 1, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0, 0);
      chk("force_paused", int'(paused), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_pause_req", int'(pause_req), 0);
      chk("async_rst_paused", int'(paused), 0);
      chk("async_rst_cnt_ovf", int'(cnt_overflow), 0);
      chk("async_rst_cnt_pevt", int'(cnt_pause_events), 0);
      chk("async_rst_cnt_pcyc", int'(cnt_pause_cycles), 0);
      chk("async_rst_cnt_good", int'(cnt_good_frame), 0);
      model_reset();
      #1 rst = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(7, 0) == 0), ($urandom_range(7, 0) != 0),
              int'($urandom_range(16, 0)), ($urandom_range(1, 0) == 1),
              ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0),
              ($urandom_range(1, 0) == 1), ($urandom_range(31, 0) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
